// File: rtl/spi_slave_word.sv
// SPI mode-0 slave (CPOL=0, CPHA=0, MSB first) running entirely in the i_clk domain.
// Pins are synchronised and edge-detected; words are shifted in on SCLK rise and out on SCLK fall.
module spi_slave_word #(
  parameter int NB_BITS = 32,
  parameter int N_SYNC  = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_sclk,
  input  logic               i_mosi,
  input  logic               i_cs_n,
  input  logic [NB_BITS-1:0] i_data,
  output logic               o_miso,
  output logic [NB_BITS-1:0] o_data,
  output logic               o_valid,
  output logic               o_busy,
  output logic               o_frame_err
);

  localparam int CW = $clog2(NB_BITS);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  logic [N_SYNC-1:0]  sclk_sync_q, sclk_sync_d;
  logic [N_SYNC-1:0]  mosi_sync_q, mosi_sync_d;
  logic [N_SYNC-1:0]  cs_sync_q,   cs_sync_d;
  logic               sclk_dly_q,  sclk_dly_d;
  logic               cs_dly_q,    cs_dly_d;
  logic [N_SYNC:0]    fill_q,      fill_d;
  logic               armed_q,     armed_d;
  state_t             state_q,     state_d;
  logic [NB_BITS-1:0] rx_q,        rx_d;
  logic [NB_BITS-1:0] tx_q,        tx_d;
  logic [CW-1:0]      cnt_q,       cnt_d;
  logic               pend_q,      pend_d;
  logic [NB_BITS-1:0] data_q,      data_d;
  logic               valid_q,     valid_d;
  logic               busy_q,      busy_d;
  logic               err_q,       err_d;

  logic sclk_s, mosi_s, cs_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  assign sclk_s    = sclk_sync_q[N_SYNC-1];
  assign mosi_s    = mosi_sync_q[N_SYNC-1];
  assign cs_s      = cs_sync_q[N_SYNC-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign cs_rise   = cs_s & ~cs_dly_q;
  // A frame only starts from a cs_n high that was really seen on the pin, so a
  // cs_n held low through reset cannot masquerade as a falling edge.
  assign cs_fall   = ~cs_s & cs_dly_q & armed_q;

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
    sclk_sync_d = {sclk_sync_q[N_SYNC-2:0], i_sclk};
    mosi_sync_d = {mosi_sync_q[N_SYNC-2:0], i_mosi};
    cs_sync_d   = {cs_sync_q[N_SYNC-2:0], i_cs_n};
    sclk_dly_d  = sclk_s;
    cs_dly_d    = cs_s;
    fill_d      = {fill_q[N_SYNC-1:0], 1'b1};
    armed_d     = armed_q | (fill_q[N_SYNC] & cs_s);
    state_d     = state_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    cnt_d       = cnt_q;
    pend_d      = 1'b0;
    data_d      = data_q;
    valid_d     = 1'b0;
    busy_d      = busy_q;
    err_d       = 1'b0;

    if (pend_q) begin
      data_d  = rx_q;
      valid_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_ACTIVE;
          tx_d    = i_data;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // cs_n rise takes priority over any SCLK edge seen in the same cycle.
        if (cs_rise) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          err_d   = (cnt_q != '0);
          cnt_d   = '0;
        end else if (sclk_rise) begin
          rx_d = {rx_q[NB_BITS-2:0], mosi_s};
          if (cnt_q == CW'(NB_BITS - 1)) begin
            cnt_d  = '0;
            pend_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (sclk_fall) begin
          tx_d = (cnt_q == '0) ? i_data : {tx_q[NB_BITS-2:0], 1'b0};
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= only, so every flop samples the pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b1;
      fill_q      <= '0;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      rx_q        <= '0;
      tx_q        <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
      sclk_dly_q  <= sclk_dly_d;
      cs_dly_q    <= cs_dly_d;
      fill_q      <= fill_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign o_miso      = (state_q == ST_ACTIVE) & tx_q[NB_BITS-1];
  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_busy      = busy_q;
  assign o_frame_err = err_q;

endmodule
